// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Round-robin front end for the 4 KB single-port SRAM macro. Two valid/ready
// request ports share one macro; each access runs SETUP -> ACCESS (-> CAPTURE
// for reads) with the macro strobes and address/data driven from registers.
module sram_port_arbiter #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   // requester A (image-load path)
   input  logic              a_req_valid,
   output logic              a_req_ready,
   input  logic              a_req_we,
   input  logic [ADDR_W-1:0] a_req_addr,
   input  logic [DATA_W-1:0] a_req_wdata,
   output logic              a_rsp_valid,
   output logic [DATA_W-1:0] a_rsp_rdata,
   // requester B (convolution datapath)
   input  logic              b_req_valid,
   output logic              b_req_ready,
   input  logic              b_req_we,
   input  logic [ADDR_W-1:0] b_req_addr,
   input  logic [DATA_W-1:0] b_req_wdata,
   output logic              b_rsp_valid,
   output logic [DATA_W-1:0] b_rsp_rdata,
   // status
   output logic              busy,
   // SRAM macro side
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_din,
   output logic              sram_write_en,
   output logic              sram_sense_en,
   input  logic [DATA_W-1:0] sram_dout
);

   localparam int NUM_REQ = 2;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, CAPTURE} state_t;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   state_t                   state;
   logic                     last_grant;   // 0 = A, 1 = B
   logic                     owner;        // requester that owns the access in flight
   logic                     op_we;
   logic [DATA_W-1:0]        rdata;        // shared read-data register for both ports
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       grant;
   logic [NUM_REQ-1:0]       rsp_pulse;
   req_t [NUM_REQ-1:0]       req;
   req_t                     win_req;
   logic                     win;

   assign req_valid = {b_req_valid, a_req_valid};
   assign req[0]    = {a_req_we, a_req_addr, a_req_wdata};
   assign req[1]    = {b_req_we, b_req_addr, b_req_wdata};

   // Grant only in IDLE and never during reset; on contention the requester
   // that was not served last wins.
   always_comb begin
      grant = '0;
      if (!reset && state == IDLE) begin
         if (req_valid[0] && (!req_valid[1] || last_grant))
            grant[0] = 1'b1;
         else if (req_valid[1])
            grant[1] = 1'b1;
      end
   end

   assign win     = grant[1];
   assign win_req = req[win];

   // Access sequencer: latches the winning request, then drives the strobes
   // with a fixed one-cycle setup before the access cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         last_grant    <= 1'b1;
         owner         <= 1'b0;
         op_we         <= 1'b0;
         sram_addr     <= '0;
         sram_din      <= '0;
         sram_write_en <= 1'b0;
         sram_sense_en <= 1'b0;
         rdata         <= '0;
         rsp_pulse     <= '0;
      end else begin
         // strobes and response pulses are single-cycle by default
         sram_write_en <= 1'b0;
         sram_sense_en <= 1'b0;
         rsp_pulse     <= '0;
         case (state)
            IDLE: begin
               if (|grant) begin
                  owner      <= win;
                  last_grant <= win;
                  op_we      <= win_req.we;
                  sram_addr  <= win_req.addr;
                  sram_din   <= win_req.wdata;
                  state      <= SETUP;
               end
            end
            SETUP: begin
               // address/data have been stable for a full cycle; fire the strobe
               sram_write_en <= op_we;
               sram_sense_en <= !op_we;
               state         <= ACCESS;
            end
            ACCESS: begin
               state <= op_we ? IDLE : CAPTURE;
            end
            CAPTURE: begin
               rdata            <= sram_dout;
               rsp_pulse[owner] <= 1'b1;
               state            <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy        = (state != IDLE);
   assign a_req_ready = grant[0];
   assign b_req_ready = grant[1];
   assign a_rsp_valid = rsp_pulse[0];
   assign b_rsp_valid = rsp_pulse[1];
   assign a_rsp_rdata = rdata;
   assign b_rsp_rdata = rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
// Self-checking bench: two requester drivers, a behavioural SRAM macro, and a
// cycle-level scoreboard that predicts grants, strobes and responses from the
// arbitration and timing rules of the block.
module tb_sram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        vld   [2];
   logic        we    [2];
   logic [11:0] addr  [2];
   logic [7:0]  wdata [2];
   logic        a_rdy, b_rdy, a_rv, b_rv, busy, wen, sen;
   logic [7:0]  a_rd, b_rd, din, dout;
   logic [11:0] saddr;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   // behavioural macro contents and reference memory (identical at start)
   logic [7:0] sram_mem [4096];
   logic [7:0] ref_mem  [4096];

   typedef struct { int cyc; logic we; } strb_t;
   typedef struct { int cyc; int port; logic [7:0] data; } rsp_t;
   strb_t strb_q [$];
   rsp_t  rsp_q  [$];

   int          free_at = 0;     // first cycle the arbiter is expected idle
   int          last_win = 1;    // last granted requester, B after reset
   logic [11:0] exp_addr = '0;
   logic [7:0]  exp_din = '0;
   logic [7:0]  exp_rdata = '0;
   logic [7:0]  act_rsp [2];
   int          n_rsp   [2];

   sram_port_arbiter dut (
      .clk          (clk),
      .reset        (rst),
      .a_req_valid  (vld[0]),
      .a_req_ready  (a_rdy),
      .a_req_we     (we[0]),
      .a_req_addr   (addr[0]),
      .a_req_wdata  (wdata[0]),
      .a_rsp_valid  (a_rv),
      .a_rsp_rdata  (a_rd),
      .b_req_valid  (vld[1]),
      .b_req_ready  (b_rdy),
      .b_req_we     (we[1]),
      .b_req_addr   (addr[1]),
      .b_req_wdata  (wdata[1]),
      .b_rsp_valid  (b_rv),
      .b_rsp_rdata  (b_rd),
      .busy         (busy),
      .sram_addr    (saddr),
      .sram_din     (din),
      .sram_write_en(wen),
      .sram_sense_en(sen),
      .sram_dout    (dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // macro model: write on write_en, registered read data after sense_en
   always @(posedge clk) begin
      if (wen === 1'b1) sram_mem[saddr] <= din;
      if (sen === 1'b1) dout <= sram_mem[saddr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
      end
   endtask

   // scoreboard monitor: pops the expected events due this cycle and compares
   always @(negedge clk) begin : mon
      logic [1:0] erdy, erv;
      logic       ew, es;
      int         win;
      erdy = '0; erv = '0; ew = 1'b0; es = 1'b0; win = -1;
      if (strb_q.size() > 0 && strb_q[0].cyc == cyc) begin
         ew = strb_q[0].we;
         es = !strb_q[0].we;
         void'(strb_q.pop_front());
      end
      if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
         erv[rsp_q[0].port] = 1'b1;
         exp_rdata = rsp_q[0].data;
         void'(rsp_q.pop_front());
      end
      if (!rst && cyc >= free_at) begin
         if (vld[0] && (!vld[1] || last_win == 1)) win = 0;
         else if (vld[1]) win = 1;
      end
      if (win >= 0) erdy[win] = 1'b1;

      chk("ready",     {b_rdy, a_rdy}, erdy);
      chk("busy",      busy, cyc < free_at);
      chk("write_en",  wen, ew);
      chk("sense_en",  sen, es);
      chk("rsp_valid", {b_rv, a_rv}, erv);
      chk("a_rdata",   a_rd, exp_rdata);
      chk("b_rdata",   b_rd, exp_rdata);
      chk("sram_addr", saddr, exp_addr);
      chk("sram_din",  din, exp_din);

      if (a_rv === 1'b1) begin act_rsp[0] = a_rd; n_rsp[0]++; end
      if (b_rv === 1'b1) begin act_rsp[1] = b_rd; n_rsp[1]++; end

      if (rst) begin
         free_at   = cyc + 1;
         last_win  = 1;
         exp_addr  = '0;
         exp_din   = '0;
         exp_rdata = '0;
         strb_q.delete();
         rsp_q.delete();
      end else if (win >= 0) begin
         last_win = win;
         exp_addr = addr[win];
         exp_din  = wdata[win];
         strb_q.push_back('{cyc: cyc + 2, we: we[win]});
         if (we[win]) begin
            ref_mem[addr[win]] = wdata[win];
            free_at = cyc + 3;
         end else begin
            rsp_q.push_back('{cyc: cyc + 4, port: win, data: ref_mem[addr[win]]});
            free_at = cyc + 4;
         end
      end
   end

   // issue one request on port p and hold it until ready; hs = handshake cycle
   task automatic do_req(input int p, input logic w, input logic [11:0] a,
                         input logic [7:0] d, output int hs);
      int n;
      n  = 0;
      hs = -1;
      vld[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
      while (hs < 0 && n < 100) begin
         @(negedge clk);
         n++;
         if ((p == 0) ? a_rdy : b_rdy) hs = cyc;
      end
      checks++;
      if (hs < 0) begin
         errors++;
         $display("FAIL req_timeout port %0d: no ready, required within 100 cycles", p);
      end
      @(posedge clk); #1;
      vld[p] = 1'b0;
   endtask

   task automatic rnd_port(input int p, input int n);
      for (int i = 0; i < n; i++) begin
         int          hs;
         logic        w;
         logic [11:0] a;
         w = 1'($urandom_range(0, 1));
         a = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 15));
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         do_req(p, w, a, 8'($urandom), hs);
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int hs, rel, h1, h2, nb;
      int ah [4];
      int bh [4];
      logic af;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         vld[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
         act_rsp[i] = '0; n_rsp[i] = 0;
      end
      for (int i = 0; i < 4096; i++) begin
         ref_mem[i]  = 8'($urandom);
         sram_mem[i] = ref_mem[i];
      end

      // reset held 3 cycles while A is already requesting
      vld[0] = 1'b1; we[0] = 1'b1; addr[0] = 12'h0A5; wdata[0] = 8'h3C;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      rel = cyc;
      do_req(0, 1'b1, 12'h0A5, 8'h3C, hs);
      chk("first_grant_a", hs, rel);
      idle_cycles(3);

      // A reads back the byte it wrote
      do_req(0, 1'b0, 12'h0A5, 8'h00, hs);
      idle_cycles(5);
      chk("read_back_0a5", act_rsp[0], 8'h3C);
      chk("b_no_rsp", n_rsp[1], 0);

      // contention: both ports request continuously
      fork
         for (int i = 0; i < 4; i++) do_req(0, 1'b1, 12'h001, 8'($urandom), ah[i]);
         for (int j = 0; j < 4; j++) do_req(1, 1'b0, 12'h002, 8'h00, bh[j]);
      join
      af = (ah[0] < bh[0]);
      for (int i = 0; i < 4; i++) begin
         if (af) chk("alternate", (bh[i] > ah[i]) && ((i == 3) ? 1'b1 : (ah[(i+1)%4] > bh[i])), 1);
         else    chk("alternate", (ah[i] > bh[i]) && ((i == 3) ? 1'b1 : (bh[(i+1)%4] > ah[i])), 1);
      end
      idle_cycles(6);

      // address extremes: A writes them, B reads both back to back
      do_req(0, 1'b1, 12'hFFF, 8'h5A, hs);
      do_req(0, 1'b1, 12'h000, 8'hA5, hs);
      do_req(1, 1'b0, 12'hFFF, 8'h00, h1);
      do_req(1, 1'b0, 12'h000, 8'h00, h2);
      chk("b2b_read_spacing", h2 - h1, 4);
      chk("read_fff", act_rsp[1], 8'h5A);
      idle_cycles(5);
      chk("read_000", act_rsp[1], 8'hA5);

      // reset during the ACCESS cycle of a read aborts it without a response
      nb = n_rsp[1];
      do_req(1, 1'b0, 12'h123, 8'h00, hs);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      idle_cycles(5);
      chk("abort_no_rsp", n_rsp[1], nb);

      // randomized mix, 100 accesses per requester
      fork
         rnd_port(0, 100);
         rnd_port(1, 100);
      join
      idle_cycles(10);
      chk("strobes_drained", strb_q.size(), 0);
      chk("rsps_drained", rsp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-requester access controller for the 4 KB single-port SRAM macro (`sram_4kb_256x128x8`, 12-bit address, 8-bit data). It sits between the image-load path (requester A) and the convolution datapath (requester B). It arbitrates round-robin between them and sequences the macro's `write_en`/`sense_en` strobes with a fixed setup/access/capture cadence. Each requester sees a valid/ready request port and a one-cycle read-response pulse.

## Interface
- ADDR_W, 12, SRAM address width
- DATA_W, 8, SRAM data width
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- a_req_valid / b_req_valid  in  1  requester has an access pending
- a_req_ready / b_req_ready  out  1  request accepted this cycle
- a_req_we / b_req_we  in  1  1 = write, 0 = read
- a_req_addr / b_req_addr  in  ADDR_W  access address
- a_req_wdata / b_req_wdata  in  DATA_W  write data
- a_rsp_valid / b_rsp_valid  out  1  one-cycle pulse: read data valid
- a_rsp_rdata / b_rsp_rdata  out  DATA_W  read data; both driven from one shared register
- busy  out  1  FSM not in IDLE
- sram_addr  out  ADDR_W  to macro addr11..addr0, registered
- sram_din  out  DATA_W  to macro din7..din0, registered
- sram_write_en  out  1  to macro write_en, registered
- sram_sense_en  out  1  to macro sense_en, registered
- sram_dout  in  DATA_W  from macro dout7..dout0

## Operation
- FSM states: IDLE, SETUP, ACCESS, CAPTURE.
- IDLE with no valid input: stay in IDLE.
- IDLE with any valid input:
  - Arbitrate; the winner's `*_req_ready` goes high combinationally that cycle. This completes the handshake.
  - Latch the winner's we, addr and wdata into `sram_addr`/`sram_din`/op register; record the owner. Next state SETUP.
- Ready is never high outside IDLE. Ready is never high for both requesters at once.
- Arbitration:
  - Single valid input: that requester wins.
  - Both valid: the requester not granted last wins.
  - `last_grant` resets to B, so A wins the first contention.
- SETUP: addr and din are stable; both strobes low. Next state ACCESS.
- ACCESS:
  - Write: `sram_write_en`=1 for exactly this cycle; next state IDLE.
  - Read: `sram_sense_en`=1 for exactly this cycle; next state CAPTURE.
- CAPTURE: register `sram_dout` into the shared rdata register. Next cycle, pulse the owner's `*_rsp_valid` for one cycle; the other requester's valid stays 0.
- `sram_addr`/`sram_din` hold their values until the next grant; they do not return to 0 in IDLE.
- `rdata` holds its value until the next read capture.
- `sram_write_en` and `sram_sense_en` are never high simultaneously. Each is never high for two consecutive cycles.
- Reset values: state IDLE; busy=0; both ready=0 (forced low while reset is high); both rsp_valid=0; rdata=0; sram_addr=0; sram_din=0; sram_write_en=0; sram_sense_en=0; last_grant=B.
- Reset mid-operation: the access is aborted and no response is issued. Strobes are low from the first edge that samples reset. A pending rsp_valid pulse is suppressed.

## Timing
- Write accepted at cycle T: SETUP at T+1, `write_en` high at T+2, back in IDLE at T+3. Next grant is possible at T+3.
  - Write throughput: one per 3 cycles.
- Read accepted at cycle T: `sense_en` high at T+2, CAPTURE at T+3, `rsp_valid` plus rdata at T+4. IDLE at T+4, so a new grant is possible in the same cycle as `rsp_valid`.
  - Read throughput: one per 4 cycles.
- The `rsp_valid` pulse overlapping a new grant is legal; they are independent.
- busy is high from T+1 through the last non-IDLE cycle.
- Requesters must hold valid, we, addr and wdata stable until ready. Inputs are sampled only in the ready cycle.

## Test plan
- Reset: hold reset 3 cycles with a_req_valid=1 -> ready=0, all outputs 0; first grant goes to A on the cycle after reset drops.
- Single write then read:
  - A writes addr 0x0A5, data 0x3C -> `write_en` pulses at T+2 with sram_addr=0x0A5 and sram_din=0x3C.
  - A reads 0x0A5 -> a_rsp_valid at T+4 with a_rsp_rdata=0x3C; b_rsp_valid stays 0.
- Contention: both valid continuously, A writes 0x001, B reads 0x002 -> grants alternate A,B,A,B. No double ready, no strobe overlap, each strobe one cycle wide.
- Back-to-back reads from B to 0xFFF then 0x000 (address extremes) -> responses at T+4 and T+8 with the correct data; sram_addr is stable from SETUP through CAPTURE.
- Reset asserted in ACCESS of a read -> sense_en low next cycle, no rsp_valid; FSM in IDLE afterwards.
- Randomized mix of 200 accesses against a scoreboard memory model -> all read data matches; per-requester response order equals request order.
